regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port (RegWrite/WN/Input) between two writeback sources: the ALU stage and the load/memory stage. The memory stage always wins. ALU writebacks that lose arbitration wait in a small in-order FIFO, and the ALU stage is back-pressured when that FIFO is full. The block also answers combinational "pending write" queries, so decode can stall on read-after-write hazards against writes not yet in the register bank.

---
 rtl/regfile_wb_arbiter_if.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load stages, the register-file write port and decode hazard queries.
// The slave side is the arbiter; the master side drives requests and queries.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wn;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_wn;
  logic [DATA_W-1:0] mem_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_wn;
  logic [DATA_W-1:0] rf_wd;

  logic [ADDR_W-1:0] q_rn1;
  logic [ADDR_W-1:0] q_rn2;
  logic              q_hit1;
  logic              q_hit2;

  logic [CNT_W-1:0]  fifo_count;

  modport slave (
    input  alu_valid, alu_wn, alu_data,
    output alu_ready,
    input  mem_valid, mem_wn, mem_data,
    output rf_we, rf_wn, rf_wd,
    input  q_rn1, q_rn2,
    output q_hit1, q_hit2,
    output fifo_count
  );

  modport master (
    output alu_valid, alu_wn, alu_data,
    input  alu_ready,
    output mem_valid, mem_wn, mem_data,
    input  rf_we, rf_wn, rf_wd,
    output q_rn1, q_rn2,
    input  q_hit1, q_hit2,
    input  fifo_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between load (priority) and ALU writebacks,
// queuing losing ALU writes in order and reporting pending writes for hazard detection.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t         fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_wn;
  logic [DATA_W-1:0] rf_wd;

  logic              mem_req_c;
  logic              alu_req_c;
  logic              empty_c;
  logic              full_c;
  logic              ready_c;
  logic              pop_c;
  logic              bypass_c;
  logic              push_c;
  logic              issue_c;
  wb_entry_t         issue_entry_c;
  logic              hit1_c;
  logic              hit2_c;

  // Writes to r0 are swallowed: they never queue, issue, or take the slot.
  assign mem_req_c = bus.mem_valid && (bus.mem_wn != '0);
  assign alu_req_c = bus.alu_valid && (bus.alu_wn != '0);
  assign empty_c   = (count == '0);
  assign full_c    = (count == CNT_W'(DEPTH));

  // A full queue can still accept when no load is competing, since the head drains this cycle.
  assign ready_c   = !full_c || !mem_req_c;
  assign pop_c     = !mem_req_c && !empty_c;
  assign bypass_c  = !mem_req_c && empty_c && alu_req_c;
  assign push_c    = alu_req_c && ready_c && !bypass_c;

  always_comb begin
    issue_c       = 1'b0;
    issue_entry_c = '0;
    if (mem_req_c) begin
      issue_c       = 1'b1;
      issue_entry_c = {bus.mem_wn, bus.mem_data};
    end else if (!empty_c) begin
      issue_c       = 1'b1;
      issue_entry_c = fifo_mem[rd_ptr];
    end else if (alu_req_c) begin
      issue_c       = 1'b1;
      issue_entry_c = {bus.alu_wn, bus.alu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we  <= 1'b0;
      rf_wn  <= '0;
      rf_wd  <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      rf_we <= issue_c;
      if (issue_c) begin
        rf_wn <= issue_entry_c.wn;
        rf_wd <= issue_entry_c.data;
      end
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Queue storage needs no reset; occupancy alone marks valid entries.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mem[wr_ptr] <= {bus.alu_wn, bus.alu_data};
    end
  end

  // Pending-write lookup covers queued entries and the write currently on the port.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (fifo_mem[idx].wn == bus.q_rn1) hit1_c = 1'b1;
        if (fifo_mem[idx].wn == bus.q_rn2) hit2_c = 1'b1;
      end
    end
    if (rf_we && (rf_wn == bus.q_rn1)) hit1_c = 1'b1;
    if (rf_we && (rf_wn == bus.q_rn2)) hit2_c = 1'b1;
    hit1_c = hit1_c && (bus.q_rn1 != '0);
    hit2_c = hit2_c && (bus.q_rn2 != '0);
  end

  assign bus.alu_ready  = ready_c;
  assign bus.rf_we      = rf_we;
  assign bus.rf_wn      = rf_wn;
  assign bus.rf_wd      = rf_wd;
  assign bus.q_hit1     = hit1_c;
  assign bus.q_hit2     = hit2_c;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_regfile_wb_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] data;
  } wr_t;

  // Reference model: pending ALU writes as a queue plus the write currently on the port.
  wr_t               mq[$];
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_wn = '0;
  logic [DATA_W-1:0] m_wd = '0;

  function automatic logic m_ready();
    return (mq.size() < int'(DEPTH)) || !(bus.mem_valid && bus.mem_wn != 0);
  endfunction

  function automatic logic m_hit(input logic [ADDR_W-1:0] rn);
    if (rn == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].wn == rn) return 1'b1;
    return m_we && (m_wn == rn);
  endfunction

  task automatic model_step();
    logic mreq, areq, rdy, direct;
    wr_t  e;
    if (rst) begin
      mq.delete();
      m_we = 1'b0; m_wn = '0; m_wd = '0;
      return;
    end
    mreq   = bus.mem_valid && bus.mem_wn != 0;
    areq   = bus.alu_valid && bus.alu_wn != 0;
    rdy    = m_ready();
    direct = 1'b0;
    if (mreq) begin
      m_we = 1'b1; m_wn = bus.mem_wn; m_wd = bus.mem_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_wn = e.wn; m_wd = e.data;
    end else if (areq) begin
      direct = 1'b1;
      m_we = 1'b1; m_wn = bus.alu_wn; m_wd = bus.alu_data;
    end else begin
      m_we = 1'b0;
    end
    if (areq && rdy && !direct) mq.push_back({bus.alu_wn, bus.alu_data});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic av, input logic [ADDR_W-1:0] awn, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [ADDR_W-1:0] mwn, input logic [DATA_W-1:0] md);
    bus.alu_valid = av; bus.alu_wn = awn; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_wn = mwn; bus.mem_data = md;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); bus.q_rn1 = '0; bus.q_rn2 = '0;
    cycle(); cycle();
    rst = 1'b0; #1;
    total++; if ({bus.rf_we, bus.rf_wn, bus.rf_wd} !== 38'h0) begin bad++;
      $display("FAIL reset_rf got=%h exp=%h", {bus.rf_we, bus.rf_wn, bus.rf_wd}, 38'h0); end
    total++; if (bus.fifo_count !== 2'd0) begin bad++;
      $display("FAIL reset_count got=%0d exp=0", bus.fifo_count); end
    total++; if (bus.alu_ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready got=%b exp=1", bus.alu_ready); end
  endtask

  task automatic test_single_alu();
    drive(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0); #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++;
      $display("FAIL single_ready got=%b exp=1", bus.alu_ready); end
    cycle(); idle(); #1;
    total++; if ({bus.rf_we, bus.rf_wn, bus.rf_wd} !== {1'b1, 5'd5, 32'h1234}) begin bad++;
      $display("FAIL single_rf got=%h exp=%h", {bus.rf_we, bus.rf_wn, bus.rf_wd}, {1'b1, 5'd5, 32'h1234}); end
    total++; if (bus.fifo_count !== 2'd0 || bus.alu_ready !== 1'b1) begin bad++;
      $display("FAIL single_count got=%0d/%b exp=0/1", bus.fifo_count, bus.alu_ready); end
    cycle(); #1;
    total++; if (bus.rf_we !== 1'b0 || bus.rf_wn !== 5'd5) begin bad++;
      $display("FAIL single_hold got=%b/%0d exp=0/5", bus.rf_we, bus.rf_wn); end
  endtask

  task automatic test_mem_alu_same_cycle();
    drive(1'b1, 5'd8, 32'hBBBB, 1'b1, 5'd7, 32'hAAAA); #1;
    total++; if (bus.alu_ready !== 1'b1) begin bad++;
      $display("FAIL both_ready got=%b exp=1", bus.alu_ready); end
    cycle(); idle(); bus.q_rn1 = 5'd8; bus.q_rn2 = 5'd7; #1;
    total++; if ({bus.rf_we, bus.rf_wn, bus.rf_wd} !== {1'b1, 5'd7, 32'hAAAA}) begin bad++;
      $display("FAIL both_mem got=%h exp=%h", {bus.rf_we, bus.rf_wn, bus.rf_wd}, {1'b1, 5'd7, 32'hAAAA}); end
    total++; if ({bus.fifo_count, bus.q_hit1, bus.q_hit2} !== {2'd1, 1'b1, 1'b1}) begin bad++;
      $display("FAIL both_q1 got=%b exp=0111", {bus.fifo_count, bus.q_hit1, bus.q_hit2}); end
    cycle(); #1;
    total++; if ({bus.rf_we, bus.rf_wn, bus.rf_wd} !== {1'b1, 5'd8, 32'hBBBB}) begin bad++;
      $display("FAIL both_alu got=%h exp=%h", {bus.rf_we, bus.rf_wn, bus.rf_wd}, {1'b1, 5'd8, 32'hBBBB}); end
    total++; if ({bus.fifo_count, bus.q_hit1, bus.q_hit2} !== {2'd0, 1'b1, 1'b0}) begin bad++;
      $display("FAIL both_q2 got=%b exp=0010", {bus.fifo_count, bus.q_hit1, bus.q_hit2}); end
    bus.q_rn1 = '0; bus.q_rn2 = '0;
    cycle();
  endtask

  task automatic test_fill_backpressure();
    logic [ADDR_W-1:0]  exp_wn [3]  = '{5'd1, 5'd2, 5'd3};
    logic [CNT_W-1:0]   exp_cnt [3] = '{2'd2, 2'd1, 2'd0};
    drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd10, 32'hA10); cycle();
    drive(1'b1, 5'd2, 32'h102, 1'b1, 5'd11, 32'hA11); #1;
    total++; if (bus.alu_ready !== 1'b1 || bus.fifo_count !== 2'd1) begin bad++;
      $display("FAIL fill_c2 got=%b/%0d exp=1/1", bus.alu_ready, bus.fifo_count); end
    cycle();
    drive(1'b1, 5'd3, 32'h103, 1'b1, 5'd12, 32'hA12); #1;
    total++; if (bus.alu_ready !== 1'b0 || bus.fifo_count !== 2'd2) begin bad++;
      $display("FAIL fill_full got=%b/%0d exp=0/2", bus.alu_ready, bus.fifo_count); end
    cycle();
    drive(1'b1, 5'd3, 32'h103, 1'b0, '0, '0); #1;
    total++; if (bus.alu_ready !== 1'b1 || bus.rf_wn !== 5'd12) begin bad++;
      $display("FAIL fill_release got=%b/%0d exp=1/12", bus.alu_ready, bus.rf_wn); end
    cycle(); idle(); #1;
    for (int i = 0; i < 3; i++) begin
      total++; if ({bus.rf_we, bus.rf_wn, bus.fifo_count} !== {1'b1, exp_wn[i], exp_cnt[i]}) begin bad++;
        $display("FAIL fill_drain%0d got=%b exp=%b", i, {bus.rf_we, bus.rf_wn, bus.fifo_count},
                 {1'b1, exp_wn[i], exp_cnt[i]}); end
      cycle(); #1;
    end
  endtask

  task automatic test_full_pop_push();
    logic [ADDR_W-1:0] exp_wn [3]  = '{5'd1, 5'd2, 5'd4};
    logic [DATA_W-1:0] exp_wd [3]  = '{32'h201, 32'h202, 32'h204};
    logic [CNT_W-1:0]  exp_cnt [3] = '{2'd2, 2'd1, 2'd0};
    drive(1'b1, 5'd1, 32'h201, 1'b1, 5'd16, 32'hB16); cycle();
    drive(1'b1, 5'd2, 32'h202, 1'b1, 5'd17, 32'hB17); cycle();
    drive(1'b1, 5'd4, 32'h204, 1'b0, '0, '0); #1;
    total++; if (bus.alu_ready !== 1'b1 || bus.fifo_count !== 2'd2) begin bad++;
      $display("FAIL pp_ready got=%b/%0d exp=1/2", bus.alu_ready, bus.fifo_count); end
    cycle(); idle(); #1;
    for (int i = 0; i < 3; i++) begin
      total++; if ({bus.rf_we, bus.rf_wn, bus.rf_wd, bus.fifo_count} !== {1'b1, exp_wn[i], exp_wd[i], exp_cnt[i]}) begin bad++;
        $display("FAIL pp_order%0d got=%h exp=%h", i, {bus.rf_we, bus.rf_wn, bus.rf_wd, bus.fifo_count},
                 {1'b1, exp_wn[i], exp_wd[i], exp_cnt[i]}); end
      cycle(); #1;
    end
  endtask

  task automatic test_reg0();
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd13, 32'h1313); cycle();
    drive(1'b1, 5'd0, 32'h5555, 1'b1, 5'd0, 32'hFFFF); bus.q_rn1 = '0; bus.q_rn2 = 5'd9; #1;
    total++; if ({bus.alu_ready, bus.fifo_count, bus.q_hit1, bus.q_hit2} !== {1'b1, 2'd1, 1'b0, 1'b1}) begin bad++;
      $display("FAIL r0_pre got=%b exp=10101", {bus.alu_ready, bus.fifo_count, bus.q_hit1, bus.q_hit2}); end
    cycle(); idle(); #1;
    total++; if ({bus.rf_we, bus.rf_wn, bus.rf_wd} !== {1'b1, 5'd9, 32'h99}) begin bad++;
      $display("FAIL r0_issue got=%h exp=%h", {bus.rf_we, bus.rf_wn, bus.rf_wd}, {1'b1, 5'd9, 32'h99}); end
    total++; if (bus.fifo_count !== 2'd0 || bus.q_hit1 !== 1'b0) begin bad++;
      $display("FAIL r0_noenq got=%0d/%b exp=0/0", bus.fifo_count, bus.q_hit1); end
    cycle(); #1;
    total++; if (bus.rf_we !== 1'b0 || bus.q_hit2 !== 1'b0) begin bad++;
      $display("FAIL r0_idle got=%b/%b exp=0/0", bus.rf_we, bus.q_hit2); end
    bus.q_rn2 = '0;
  endtask

  task automatic test_hazard_reset();
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd14, 32'h1414); cycle();
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd15, 32'h1515); bus.q_rn1 = 5'd6; bus.q_rn2 = 5'd9; #1;
    total++; if ({bus.q_hit1, bus.q_hit2, bus.fifo_count} !== {1'b1, 1'b0, 2'd1}) begin bad++;
      $display("FAIL hz_hit got=%b exp=1001", {bus.q_hit1, bus.q_hit2, bus.fifo_count}); end
    rst = 1'b1; cycle(); rst = 1'b0; idle(); #1;
    total++; if ({bus.rf_we, bus.fifo_count, bus.q_hit1} !== {1'b0, 2'd0, 1'b0}) begin bad++;
      $display("FAIL hz_rst got=%b exp=0000", {bus.rf_we, bus.fifo_count, bus.q_hit1}); end
    cycle(); #1;
    total++; if (bus.rf_we !== 1'b0) begin bad++;
      $display("FAIL hz_postrst got=%b exp=0", bus.rf_we); end
    bus.q_rn1 = '0; bus.q_rn2 = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive(1'($urandom_range(0, 2) != 0), ADDR_W'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 4) < 2), ADDR_W'($urandom_range(0, 7)), $urandom());
      bus.q_rn1 = ADDR_W'($urandom_range(0, 7));
      bus.q_rn2 = ADDR_W'($urandom_range(0, 7));
      #1;
      total++; if (bus.alu_ready !== m_ready()) begin bad++;
        $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.alu_ready, m_ready()); end
      total++; if (bus.fifo_count !== CNT_W'(mq.size())) begin bad++;
        $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, bus.fifo_count, mq.size()); end
      total++; if ({bus.q_hit1, bus.q_hit2} !== {m_hit(bus.q_rn1), m_hit(bus.q_rn2)}) begin bad++;
        $display("FAIL rnd_hit n=%0d got=%b exp=%b", n, {bus.q_hit1, bus.q_hit2},
                 {m_hit(bus.q_rn1), m_hit(bus.q_rn2)}); end
      total++; if ({bus.rf_we, bus.rf_wn, bus.rf_wd} !== {m_we, m_wn, m_wd}) begin bad++;
        $display("FAIL rnd_rf n=%0d got=%h exp=%h", n, {bus.rf_we, bus.rf_wn, bus.rf_wd}, {m_we, m_wn, m_wd}); end
      cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.q_rn1 = '0;
    bus.q_rn2 = '0;
    @(negedge clk);
    test_reset();
    test_single_alu();
    test_mem_alu_same_cycle();
    test_fill_backpressure();
    test_full_pop_push();
    test_reg0();
    test_hazard_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
